// File: rtl/adc_pkg.sv
// Shared constants for the 10-bit SAR ADC controller and its comparator model.
//   ADC_N_BITS    : SAR resolution in bits
//   ADC_MID_SCALE : input code applied during calibration
//   OFS_W         : width of the signed offset register
//   RES_MIN/MAX   : saturation limits for the corrected result
//   RED_DROP      : LSBs skipped in reduced (8-bit) mode
package adc_pkg;
  localparam int ADC_N_BITS    = 10;
  localparam int ADC_MID_SCALE = 512;
  localparam int OFS_W         = 11;
  localparam int RES_MIN       = 0;
  localparam int RES_MAX       = 1023;
  localparam int RED_DROP      = 2;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SAMPLE,
    PH_REQ,
    PH_CMP,
    PH_DONE
  } phase_e;
endpackage

// File: rtl/ideal_comparator_10b_signed.sv
// Behavioural comparator partner for adc_fsm_10b.
//   vip, vin    : positive / negative inputs (unsigned codes)
//   osc         : signed offset added to vip
//   clk         : fire request (adc clkout)
//   rst         : async active-high reset
//   comp_result : 1 when vip + osc >= vin, held until the next rising clk
//   comp_done   : high from rising clk until falling clk
module ideal_comparator_10b_signed
  import adc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic        [ADC_N_BITS-1:0] vip,
  input  logic        [ADC_N_BITS-1:0] vin,
  input  logic signed [ADC_N_BITS-1:0] osc,
  output logic                         comp_result,
  output logic                         comp_done
);
  localparam int CMP_W = ADC_N_BITS + 2;

  logic signed [CMP_W-1:0] lhs;
  logic signed [CMP_W-1:0] rhs;
  logic                    rise_tog;
  logic                    fall_tog;

  assign lhs = $signed({2'b00, vip}) + $signed({{2{osc[ADC_N_BITS-1]}}, osc});
  assign rhs = $signed({2'b00, vin});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_result <= 1'b0;
      rise_tog    <= 1'b0;
    end else begin
      comp_result <= (lhs >= rhs);
      rise_tog    <= ~rise_tog;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) fall_tog <= 1'b0;
    else     fall_tog <= ~fall_tog;
  end

  // Done is high between a rising and the following falling clk edge.
  assign comp_done = rise_tog ^ fall_tog;
endmodule

// File: rtl/adc_fsm_10b.sv
// SAR ADC controller, self-timed by the comparator-done strobe (no free clock).
//   clkin     : comparator-done strobe, both edges used
//   rst       : async active-high reset
//   st_conv   : high = sample, falling edge starts conversion, rise aborts
//   clkout    : fire-comparator request
//   comp_in   : comparator decision, 1 = input >= DAC
//   sample    : sampling switch
//   dac_value : DAC trial code (dac_msb/dac_lsb are its halves)
//   result    : offset-corrected, saturated code
//   adc_done  : conversion complete
//   sel_12b   : 1 = full resolution, 0 = 8 bits with result[1:0] = 0
//   cal       : calibration request, captured at st_conv rise
module adc_fsm_10b
  import adc_pkg::*;
#(
  parameter int N_BITS    = ADC_N_BITS,
  parameter int MID_SCALE = ADC_MID_SCALE
)
(
  input  logic                    clkin,
  input  logic                    rst,
  input  logic                    st_conv,
  input  logic                    comp_in,
  input  logic                    sel_12b,
  input  logic                    cal,
  output logic                    clkout,
  output logic                    sample,
  output logic [N_BITS-1:0]       dac_value,
  output logic [N_BITS-N_BITS/2-1:0] dac_msb,
  output logic [N_BITS/2-1:0]     dac_lsb,
  output logic [N_BITS-1:0]       result,
  output logic                    adc_done
);
  localparam int CW = $clog2(N_BITS + 1);
  localparam int DW = OFS_W + 1;
  localparam logic signed [DW-1:0] SAT_LO  = DW'(RES_MIN);
  localparam logic signed [DW-1:0] SAT_HI  = DW'(RES_MAX);
  localparam logic [N_BITS-1:0]    LO_MASK = N_BITS'((1 << RED_DROP) - 1);

  phase_e                   phase;
  logic                     armed;
  logic                     cal_mode;
  logic                     full_mode;
  logic                     sar_clr;
  logic [CW-1:0]            n_rise;
  logic [CW-1:0]            n_fall;
  logic [CW-1:0]            n_cmp;
  logic [CW-1:0]            idx;
  logic [N_BITS-1:0]        code;
  logic [N_BITS-1:0]        bit_mask;
  logic [N_BITS-1:0]        raw;
  logic [N_BITS-1:0]        res_new;
  logic signed [OFS_W-1:0]  offset_reg;
  logic signed [OFS_W-1:0]  ofs_cal;
  logic signed [OFS_W-1:0]  ofs_new;
  logic signed [DW-1:0]     diff;
  logic                     accept_rise;
  logic                     accept_fall;
  logic                     last_rise;

  function automatic logic [N_BITS-1:0] sat_code(input logic signed [DW-1:0] v);
    if (v < SAT_LO)      return N_BITS'(RES_MIN);
    else if (v > SAT_HI) return N_BITS'(RES_MAX);
    else                 return v[N_BITS-1:0];
  endfunction

  // st_conv is also an async clear: while it is high the SAR is held at its start point.
  assign sar_clr = rst | st_conv;

  // Start-of-conversion capture
  always_ff @(posedge st_conv or posedge rst) begin
    if (rst) begin
      armed     <= 1'b0;
      cal_mode  <= 1'b0;
      full_mode <= 1'b0;
    end else begin
      armed     <= 1'b1;
      cal_mode  <= cal;
      full_mode <= sel_12b;
    end
  end

  // Phase decode from the rise/fall compare counters
  always_comb begin
    phase = PH_IDLE;
    if (rst || !armed)       phase = PH_IDLE;
    else if (st_conv)        phase = PH_SAMPLE;
    else if (n_fall == n_cmp) phase = PH_DONE;
    else if (n_rise == n_fall) phase = PH_REQ;
    else                     phase = PH_CMP;
  end

  assign n_cmp       = full_mode ? CW'(N_BITS) : CW'(N_BITS - RED_DROP);
  assign idx         = CW'(N_BITS - 1) - n_fall;
  assign bit_mask    = {{(N_BITS-1){1'b0}}, 1'b1} << idx;
  assign raw         = code | (comp_in ? bit_mask : '0);
  assign accept_rise = (phase == PH_REQ);
  assign accept_fall = (phase == PH_CMP);
  assign last_rise   = accept_rise && (n_rise == n_cmp - CW'(1));

  // A calibration conversion uses the offset it is about to store.
  assign ofs_cal = $signed(OFS_W'(raw)) - $signed(OFS_W'(MID_SCALE));
  assign ofs_new = cal_mode ? ofs_cal : offset_reg;
  assign diff    = $signed(DW'(raw)) - $signed({ofs_new[OFS_W-1], ofs_new});
  assign res_new = full_mode ? sat_code(diff) : (sat_code(diff) & ~LO_MASK);

  // Compare capture on the rising strobe
  always_ff @(posedge clkin or posedge sar_clr) begin
    if (sar_clr) begin
      n_rise <= '0;
      code   <= '0;
    end else if (accept_rise) begin
      n_rise <= n_rise + CW'(1);
      code   <= raw;
    end
  end

  // Advance to the next bit on the falling strobe
  always_ff @(negedge clkin or posedge sar_clr) begin
    if (sar_clr)          n_fall <= '0;
    else if (accept_fall) n_fall <= n_fall + CW'(1);
  end

  // Result and offset survive st_conv; only rst clears them.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      result     <= '0;
      offset_reg <= '0;
    end else if (last_rise) begin
      result <= res_new;
      if (cal_mode) offset_reg <= ofs_cal;
    end
  end

  assign clkout    = (phase == PH_REQ);
  assign sample    = (phase == PH_SAMPLE);
  assign adc_done  = (phase == PH_DONE);
  assign dac_value = (phase == PH_REQ || phase == PH_CMP) ? (code | bit_mask) : code;
  assign dac_msb   = dac_value[N_BITS-1:N_BITS/2];
  assign dac_lsb   = dac_value[N_BITS/2-1:0];
endmodule

// File: tb/tb_adc_fsm_10b.sv
module tb_adc_fsm_10b;
  logic              clkin;
  logic              rst;
  logic              st_conv;
  logic              comp_in;
  logic              sel_12b;
  logic              cal;
  logic              clkout;
  logic              sample;
  logic [9:0]        dac_value;
  logic [4:0]        dac_msb;
  logic [4:0]        dac_lsb;
  logic [9:0]        result;
  logic              adc_done;

  logic [9:0]        ref_code;
  logic signed [9:0] osc;
  logic              comp_done;
  logic              cmp_clk;
  logic              clkin_auto;
  logic              clk_man;
  logic              use_man;

  int                checks;
  int                errors;
  int                pulse_total;
  logic [9:0]        dac_log [16];

  adc_fsm_10b dut (
    .clkin     (clkin),
    .rst       (rst),
    .st_conv   (st_conv),
    .comp_in   (comp_in),
    .sel_12b   (sel_12b),
    .cal       (cal),
    .clkout    (clkout),
    .sample    (sample),
    .dac_value (dac_value),
    .dac_msb   (dac_msb),
    .dac_lsb   (dac_lsb),
    .result    (result),
    .adc_done  (adc_done)
  );

  ideal_comparator_10b_signed cmp (
    .clk         (cmp_clk),
    .rst         (rst),
    .vip         (ref_code),
    .vin         (dac_value),
    .osc         (osc),
    .comp_result (comp_in),
    .comp_done   (comp_done)
  );

  // Self-timed ring: clkout -> comparator clk -> comp_done -> clkin, 1 unit per hop.
  initial cmp_clk = 1'b0;
  initial clkin_auto = 1'b0;
  always @(clkout) begin
    #1 cmp_clk = clkout;
  end
  always @(comp_done) begin
    #1 clkin_auto = comp_done;
  end
  assign clkin = use_man ? clk_man : clkin_auto;

  initial pulse_total = 0;
  always @(posedge cmp_clk) begin
    dac_log[pulse_total % 16] = dac_value;
    pulse_total = pulse_total + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_conv(input int r, input logic c, input logic full);
    ref_code = 10'(r);
    cal      = c;
    sel_12b  = full;
    #1 st_conv = 1'b1;
    #1 chk_eq("sample_hi", 32'(sample), 1);
    #1 st_conv = 1'b0;
    for (int k = 0; k < 100 && !adc_done; k++) #1;
    chk_eq("done", 32'(adc_done), 1);
    #1;
  endtask

  int base;
  int exp_seq [10] = '{512, 768, 640, 704, 672, 688, 696, 700, 702, 701};

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    st_conv  = 1'b0;
    sel_12b  = 1'b1;
    cal      = 1'b0;
    ref_code = '0;
    osc      = '0;
    clk_man  = 1'b0;
    use_man  = 1'b0;

    // Reset state
    #3;
    chk_eq("rst_clkout", 32'(clkout), 0);
    chk_eq("rst_sample", 32'(sample), 0);
    chk_eq("rst_done", 32'(adc_done), 0);
    chk_eq("rst_dac", 32'(dac_value), 0);
    chk_eq("rst_result", 32'(result), 0);
    chk_eq("rst_offset", 32'(dut.offset_reg), 0);
    #2 rst = 1'b0;

    // Idle clkin toggles are ignored
    use_man = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 clk_man = 1'b1;
      #2 clk_man = 1'b0;
    end
    #1;
    chk_eq("idle_clkout", 32'(clkout), 0);
    chk_eq("idle_dac", 32'(dac_value), 0);
    chk_eq("idle_done", 32'(adc_done), 0);
    chk_eq("idle_result", 32'(result), 0);
    use_man = 1'b0;
    #2;

    // Basic conversion, ref 700
    base = pulse_total;
    run_conv(700, 1'b0, 1'b1);
    chk_eq("basic_pulses", 32'(pulse_total - base), 10);
    for (int i = 0; i < 10; i++)
      chk_eq($sformatf("basic_dac%0d", i), 32'(dac_log[(base + i) % 16]), 32'(exp_seq[i]));
    chk_eq("basic_result", 32'(result), 700);
    chk_eq("basic_raw", 32'(dac_value), 700);
    chk_eq("basic_msb", 32'(dac_msb), 21);
    chk_eq("basic_lsb", 32'(dac_lsb), 28);
    chk_eq("basic_clkout", 32'(clkout), 0);
    #10;
    chk_eq("hold_result", 32'(result), 700);
    chk_eq("hold_done", 32'(adc_done), 1);

    // Uncalibrated offset
    osc = 10'sd100;
    run_conv(300, 1'b0, 1'b1);
    chk_eq("uncal_300", 32'(result), 400);
    run_conv(950, 1'b0, 1'b1);
    chk_eq("uncal_950_sat", 32'(result), 1023);

    // Calibration then corrected conversions
    run_conv(512, 1'b1, 1'b1);
    chk_eq("cal_raw", 32'(dac_value), 612);
    chk_eq("cal_offset", 32'(dut.offset_reg), 100);
    chk_eq("cal_result", 32'(result), 512);
    run_conv(300, 1'b0, 1'b1);
    chk_eq("corr_300", 32'(result), 300);
    run_conv(0, 1'b0, 1'b1);
    chk_eq("corr_0", 32'(result), 0);
    run_conv(950, 1'b0, 1'b1);
    chk_eq("corr_950", 32'(result), 923);

    // Full sweep, uncalibrated then calibrated
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    for (int r = 0; r < 1024; r++) begin
      run_conv(r, 1'b0, 1'b1);
      chk_eq($sformatf("sweep_uncal_%0d", r), 32'(result), 32'((r + 100 > 1023) ? 1023 : r + 100));
    end
    run_conv(512, 1'b1, 1'b1);
    for (int r = 0; r < 1024; r++) begin
      run_conv(r, 1'b0, 1'b1);
      chk_eq($sformatf("sweep_cal_%0d", r), 32'(result), 32'((r > 923) ? 923 : r));
    end

    // Reset during compare 5
    osc      = '0;
    ref_code = 10'd700;
    cal      = 1'b0;
    sel_12b  = 1'b1;
    base     = pulse_total;
    #1 st_conv = 1'b1;
    #2 st_conv = 1'b0;
    for (int k = 0; k < 100 && (pulse_total - base) < 5; k++) #1;
    chk_eq("abort_reached5", 32'(pulse_total - base), 5);
    rst = 1'b1;
    #1;
    chk_eq("abort_clkout", 32'(clkout), 0);
    chk_eq("abort_done", 32'(adc_done), 0);
    chk_eq("abort_offset", 32'(dut.offset_reg), 0);
    chk_eq("abort_result", 32'(result), 0);
    #4 rst = 1'b0;
    #4;
    chk_eq("abort_idle_clkout", 32'(clkout), 0);
    run_conv(700, 1'b0, 1'b1);
    chk_eq("after_abort", 32'(result), 700);

    // st_conv re-raised mid-conversion restarts cleanly
    base = pulse_total;
    ref_code = 10'd300;
    #1 st_conv = 1'b1;
    #2 st_conv = 1'b0;
    for (int k = 0; k < 100 && (pulse_total - base) < 3; k++) #1;
    run_conv(300, 1'b0, 1'b1);
    chk_eq("restart_result", 32'(result), 300);

    // Reduced resolution
    base = pulse_total;
    run_conv(701, 1'b0, 1'b0);
    chk_eq("red_pulses", 32'(pulse_total - base), 8);
    chk_eq("red_result", 32'(result), 700);
    chk_eq("red_lsbs", 32'(result[1:0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_fsm_10b.md
ADC_FSM_10B -- requirements
Module: adc_fsm_10b

Interface
REQ-001 SHALL have parameter N_BITS, default 10, meaning the SAR resolution in bits.
REQ-002 SHALL have parameter MID_SCALE, default 512, meaning the calibration input code.
REQ-003 SHALL have port clkin, input, 1 bit: comparator-done strobe; the only timing source, since there is no free-running clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port st_conv, input, 1 bit: start pulse; high = sample phase, falling edge starts the conversion.
REQ-006 SHALL have port clkout, output, 1 bit: fire-comparator request.
REQ-007 SHALL have port comp_in, input, 1 bit: comparator decision; 1 = input >= DAC.
REQ-008 SHALL have port sample, output, 1 bit: sampling-switch control.
REQ-009 SHALL have port dac_value, output, 10 bits: DAC trial code.
REQ-010 SHALL have ports dac_msb (output, 5 bits) = dac_value[9:5] and dac_lsb (output, 5 bits) = dac_value[4:0].
REQ-011 SHALL have port result, output, 10 bits: offset-corrected conversion code.
REQ-012 SHALL have port adc_done, output, 1 bit: conversion complete.
REQ-013 SHALL have port sel_12b, input, 1 bit: 1 = full 10-bit conversion; 0 = 8-bit conversion with result[1:0] forced to 0.
REQ-014 SHALL have port cal, input, 1 bit: calibration request, sampled at the st_conv rising edge.

Function
REQ-015 SHALL, on st_conv rising: set sample=1, clear adc_done, clkout=0, and the code register, and latch cal into cal_mode; an st_conv rise mid-conversion aborts and restarts.
REQ-016 SHALL, on st_conv falling: set sample=0, bit index=9, dac_value=512, clkout=1.
REQ-017 SHALL, on clkin rising: write comp_in into code[index] (the trial bit is kept if comp_in=1, cleared if 0), then set clkout=0.
REQ-018 SHALL, on clkin falling when bits remain: decrement the index, set dac_value = code | (1<<index), and set clkout=1.
REQ-019 SHALL run 10 compare cycles when sel_12b=1 and 8 cycles when sel_12b=0; after the last compare, dac_value holds the final raw code.
REQ-020 SHALL, on the clkin rising edge of the last bit, compute raw, then update result, and then offset_reg if cal_mode; adc_done SHALL rise on the following clkin falling edge, so result is stable before adc_done rises.
REQ-021 SHALL, when cal_mode=1, set offset_reg (11-bit signed) = raw - MID_SCALE.
REQ-022 SHALL set result = raw - offset_reg, saturated to the range 0..1023, using the new offset_reg during a calibration conversion.
REQ-023 SHALL hold adc_done=1 and result until the next st_conv rising edge or rst; clkin edges while idle SHALL be ignored.

Reset
REQ-024 SHALL, while rst=1, force clkout=0, sample=0, adc_done=0, dac_value=0, result=0, offset_reg=0, index=9, cal_mode=0, at any point including mid-conversion.
REQ-025 SHALL, after rst is released, remain idle until an st_conv rising edge.

Structure
REQ-026 SHALL place N_BITS, MID_SCALE, the offset width (11) and the saturation limits (0, 1023) in shared package adc_pkg.
REQ-027 SHALL use the sub-module ideal_comparator_10b_signed (ports vip[9:0], vin[9:0], osc[9:0] signed, clk, rst, comp_result, comp_done) as the behavioural partner.
REQ-028 SHALL, in ideal_comparator_10b_signed: on clk rising, set comp_result = (vip + osc >= vin) evaluated in 12-bit signed, then comp_done=1; on clk falling, set comp_done=0 and hold comp_result; rst clears both outputs.

Verification
REQ-029 SHALL verify reset: rst pulse -> all outputs 0, offset_reg=0; a subsequent clkin toggle -> no change.
REQ-030 SHALL verify a basic conversion: osc=0, ref=700, sel_12b=1 -> dac_value sequence 512,768,640,704,672,688,696,700,702,701; 10 clkout pulses; result=700.
REQ-031 SHALL verify uncalibrated offset: osc=100, cal=0 -> ref=300 gives result 400; ref=950 gives result 1023 (saturated).
REQ-032 SHALL verify calibration: osc=100, cal=1, ref=512 -> raw 612, offset_reg=100, result 512; then with cal=0, ref=300 -> 300, ref=0 -> 0, ref=950 -> 923.
REQ-033 SHALL verify a full sweep: ref 0..1023 in steps of 1, 40-time-unit conversion spacing, osc=100 -> the uncalibrated ADC reports min(ref+100,1023) and the calibrated ADC reports min(ref,923).
REQ-034 SHALL verify abort and reduced resolution: rst at compare 5 -> clkout=0, adc_done=0, offset_reg=0, and the next conversion is correct; sel_12b=0, ref=701, osc=0 -> 8 compares, result 700.
